// File: rtl/echo_divider_if.sv
// ---------------------------------------------------------------------------
// echo_divider_if
//   Request/result bundle for the echo divider.
//   Requester side (master) drives the start strobe and operands. Divider
//   side (slave) returns status and result.
//
//   calculate  master->slave  1       start request, honoured only when idle
//   count      master->slave  WIDTH   dividend (raw echo count)
//   divisor    master->slave  DWIDTH  runtime divisor
//   busy       slave->master  1       division in progress
//   DONE       slave->master  1       result valid (level)
//   d          slave->master  WIDTH   quotient, optionally rounded
//   rem        slave->master  WIDTH   unrounded remainder
//   div_zero   slave->master  1       last accepted request had divisor 0
// ---------------------------------------------------------------------------
interface echo_divider_if #(
  parameter int WIDTH  = 16,
  parameter int DWIDTH = 8
) ();

  logic              calculate;
  logic [WIDTH-1:0]  count;
  logic [DWIDTH-1:0] divisor;
  logic              busy;
  logic              DONE;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  rem;
  logic              div_zero;

  modport master (
    output calculate, count, divisor,
    input  busy, DONE, d, rem, div_zero
  );

  modport slave (
    input  calculate, count, divisor,
    output busy, DONE, d, rem, div_zero
  );

endinterface

// File: rtl/echo_divider.sv
// ---------------------------------------------------------------------------
// echo_divider
//   Sequential restoring divider converting a raw ultrasonic echo count into
//   a distance value. One quotient bit is resolved per clock, MSB first.
//   Optional round-half-up of the quotient and a divide-by-zero flag.
//
//   Parameters
//     WIDTH   width of dividend, quotient and remainder
//     DWIDTH  width of divisor (DWIDTH <= WIDTH)
//     ROUND   0 = truncate, 1 = round half up using the remainder
//
//   Ports
//     CLKOUTD  in   clock, all state changes on the rising edge
//     reset    in   asynchronous active-low reset; aborts any division
//     bus      slave side of echo_divider_if (request in, result out)
//
//   Timing: request accepted on edge 0; DONE visible after edge WIDTH+1
//   (edge 1 for divisor 0). All outputs come straight from registers.
// ---------------------------------------------------------------------------
module echo_divider #(
  parameter int WIDTH  = 16,
  parameter int DWIDTH = 8,
  parameter int ROUND  = 0
) (
  input  logic          CLKOUTD,
  input  logic          reset,
  echo_divider_if.slave bus
);

  localparam int ITER_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_reg;

  // Working registers
  logic [WIDTH-1:0]  dividend_reg;   // latched count, shifted left during RUN
  logic [DWIDTH-1:0] divisor_reg;
  logic [WIDTH:0]    part_reg;       // partial remainder, one spare bit
  logic [WIDTH-1:0]  quot_reg;
  logic [ITER_W-1:0] iter_reg;
  logic              zero_reg;

  // Output registers
  logic              busy_reg;
  logic              done_reg;
  logic [WIDTH-1:0]  d_reg;
  logic [WIDTH-1:0]  rem_reg;
  logic              div_zero_reg;

  // One restoring step
  logic [WIDTH:0]    divisor_ext;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic              fits;

  // Final rounding
  logic [WIDTH+1:0]  rem_x2;
  logic              round_up;
  logic [WIDTH-1:0]  quot_final;

  always_comb begin
    divisor_ext = {{(WIDTH + 1 - DWIDTH){1'b0}}, divisor_reg};
    // Bring down the next dividend bit. The partial remainder is always
    // below the divisor, so the dropped top bit is guaranteed zero.
    shifted     = {part_reg[WIDTH-1:0], dividend_reg[WIDTH-1]};
    fits        = (shifted >= divisor_ext);
    diff        = shifted - divisor_ext;
  end

  always_comb begin
    rem_x2     = {part_reg, 1'b0};
    // Round half up: remainder at least half the divisor. Cannot overflow
    // since divisor 1 leaves remainder 0 and divisor >= 2 halves the range.
    round_up   = (ROUND != 0) && (rem_x2 >= {1'b0, divisor_ext});
    quot_final = quot_reg + {{(WIDTH - 1){1'b0}}, round_up};
  end

  always_ff @(posedge CLKOUTD or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      part_reg     <= '0;
      quot_reg     <= '0;
      iter_reg     <= '0;
      zero_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      d_reg        <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.calculate) begin
            dividend_reg <= bus.count;
            divisor_reg  <= bus.divisor;
            part_reg     <= '0;
            quot_reg     <= '0;
            iter_reg     <= ITER_W'(WIDTH);
            busy_reg     <= 1'b1;
            // Only DONE and the flag clear here; d/rem keep the old result
            // until the next FINISH.
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            if (bus.divisor == '0) begin
              zero_reg  <= 1'b1;
              state_reg <= FINISH;
            end else begin
              zero_reg  <= 1'b0;
              state_reg <= RUN;
            end
          end
        end

        RUN: begin
          part_reg     <= fits ? diff : shifted;
          quot_reg     <= {quot_reg[WIDTH-2:0], fits};
          dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
          iter_reg     <= iter_reg - ITER_W'(1);
          if (iter_reg == ITER_W'(1)) begin
            state_reg <= FINISH;
          end
        end

        FINISH: begin
          if (zero_reg) begin
            // Saturated quotient; the dividend was never shifted, so it
            // still holds the original count.
            d_reg        <= '1;
            rem_reg      <= dividend_reg;
            div_zero_reg <= 1'b1;
          end else begin
            d_reg        <= quot_final;
            rem_reg      <= part_reg[WIDTH-1:0];
            div_zero_reg <= 1'b0;
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.DONE     = done_reg;
  assign bus.d        = d_reg;
  assign bus.rem      = rem_reg;
  assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_echo_divider.sv
// ---------------------------------------------------------------------------
// tb_echo_divider
//   Two divider instances (truncating and rounding) see identical stimulus.
//   Each accepted request pushes the expected outcome, derived with plain
//   integer division, into a per-instance queue; a monitor per instance pops
//   and compares when DONE rises, including the edge on which it rose.
// ---------------------------------------------------------------------------
module tb_echo_divider;

  localparam int WIDTH  = 16;
  localparam int DWIDTH = 8;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vecs = 0;
  int   fails = 0;

  echo_divider_if #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) bus0 ();
  echo_divider_if #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) bus1 ();

  echo_divider #(.WIDTH(WIDTH), .DWIDTH(DWIDTH), .ROUND(0)) dut0 (
    .CLKOUTD (clk),
    .reset   (rst_n),
    .bus     (bus0)
  );

  echo_divider #(.WIDTH(WIDTH), .DWIDTH(DWIDTH), .ROUND(1)) dut1 (
    .CLKOUTD (clk),
    .reset   (rst_n),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] c;
    logic [7:0]  v;
    logic [15:0] d;
    logic [15:0] rem;
    logic        dz;
    int          done_cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t model(input logic [15:0] c, input logic [7:0] v,
                                 input bit rnd, input int acc);
    exp_t e;
    int unsigned q, r;
    e.c = c;
    e.v = v;
    if (v == 8'd0) begin
      e.d        = 16'hFFFF;
      e.rem      = c;
      e.dz       = 1'b1;
      e.done_cyc = acc + 1;
    end else begin
      q = 32'(c) / 32'(v);
      r = 32'(c) % 32'(v);
      if (rnd && (2 * r >= 32'(v))) q = q + 1;
      e.d        = q[15:0];
      e.rem      = r[15:0];
      e.dz       = 1'b0;
      e.done_cyc = acc + WIDTH + 1;
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic drive(input logic calc, input logic [15:0] c, input logic [7:0] v);
    bus0.calculate = calc; bus0.count = c; bus0.divisor = v;
    bus1.calculate = calc; bus1.count = c; bus1.divisor = v;
  endtask

  task automatic push(input logic [15:0] c, input logic [7:0] v, input int acc);
    q0.push_back(model(c, v, 1'b0, acc));
    q1.push_back(model(c, v, 1'b1, acc));
  endtask

  // Issue one request as soon as the divider is idle; returns after the
  // accepting edge with calculate deasserted.
  task automatic issue(input logic [15:0] c, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (bus0.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) cmp("issue_idle_timeout", 32'(bus0.busy), 32'd0);
    drive(1'b1, c, v);
    @(posedge clk);
    #1;
    push(c, v, cyc);
    drive(1'b0, c, v);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      cmp("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    cmp({tag, " busy0"}, 32'(bus0.busy), 32'd0);
    cmp({tag, " done0"}, 32'(bus0.DONE), 32'd0);
    cmp({tag, " d0"}, 32'(bus0.d), 32'd0);
    cmp({tag, " rem0"}, 32'(bus0.rem), 32'd0);
    cmp({tag, " dz0"}, 32'(bus0.div_zero), 32'd0);
    cmp({tag, " busy1"}, 32'(bus1.busy), 32'd0);
    cmp({tag, " done1"}, 32'(bus1.DONE), 32'd0);
    cmp({tag, " d1"}, 32'(bus1.d), 32'd0);
    cmp({tag, " rem1"}, 32'(bus1.rem), 32'd0);
    cmp({tag, " dz1"}, 32'(bus1.div_zero), 32'd0);
  endtask

  // ---- monitors ----------------------------------------------------------
  logic done0_prev = 1'b0;
  logic done1_prev = 1'b0;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.DONE && !done0_prev) begin
      if (q0.size() == 0) begin
        cmp("r0 unexpected_done", 32'(bus0.DONE), 32'd0);
      end else begin
        e = q0.pop_front();
        cmp("r0 d", 32'(bus0.d), 32'(e.d));
        cmp("r0 rem", 32'(bus0.rem), 32'(e.rem));
        cmp("r0 div_zero", 32'(bus0.div_zero), 32'(e.dz));
        cmp("r0 done_edge", 32'(cyc), 32'(e.done_cyc));
        cmp("r0 busy_at_done", 32'(bus0.busy), 32'd0);
        $display("trunc %0d/%0d -> d=%0d rem=%0d dz=%0d at edge %0d",
                 e.c, e.v, bus0.d, bus0.rem, bus0.div_zero, cyc);
      end
    end
    done0_prev = bus0.DONE;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.DONE && !done1_prev) begin
      if (q1.size() == 0) begin
        cmp("r1 unexpected_done", 32'(bus1.DONE), 32'd0);
      end else begin
        e = q1.pop_front();
        cmp("r1 d", 32'(bus1.d), 32'(e.d));
        cmp("r1 rem", 32'(bus1.rem), 32'(e.rem));
        cmp("r1 div_zero", 32'(bus1.div_zero), 32'(e.dz));
        cmp("r1 done_edge", 32'(cyc), 32'(e.done_cyc));
        cmp("r1 busy_at_done", 32'(bus1.busy), 32'd0);
        $display("round %0d/%0d -> d=%0d rem=%0d dz=%0d at edge %0d",
                 e.c, e.v, bus1.d, bus1.rem, bus1.div_zero, cyc);
      end
    end
    done1_prev = bus1.DONE;
  end

  // ---- stimulus ----------------------------------------------------------
  initial begin : stim
    int acc;
    logic [15:0] c;
    logic [7:0]  v;
    int sel;

    rst_n = 1'b0;
    drive(1'b0, 16'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(16'd1000, 8'd58);
    drain();
    issue(16'd1030, 8'd58);
    drain();
    issue(16'd255, 8'd2);
    drain();
    issue(16'd0, 8'd2);
    drain();
    issue(16'h1234, 8'd0);
    drain();
    issue(16'hFFFF, 8'd1);
    drain();
    issue(16'hFFFF, 8'd255);
    drain();

    // Request during RUN with different operands is ignored
    issue(16'd1000, 8'd58);
    repeat (3) @(negedge clk);
    drive(1'b1, 16'd5, 8'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'd7, 8'd3);
    drain();

    // Reset at edge 5 of a RUN aborts it; outputs cleared, no DONE follows
    issue(16'd4000, 8'd37);
    acc = cyc;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Back-to-back with calculate held high; operand change while busy ignored
    @(negedge clk);
    drive(1'b1, 16'd100, 8'd7);
    @(posedge clk);
    #1;
    acc = cyc;
    push(16'd100, 8'd7, acc);
    push(16'd200, 8'd9, acc + WIDTH + 2);
    drive(1'b1, 16'd200, 8'd9);
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    cmp("b2b done_before_accept", 32'(bus0.DONE), 32'd1);
    @(posedge clk);
    #1;
    cmp("b2b done_cleared", 32'(bus0.DONE), 32'd0);
    cmp("b2b busy_again", 32'(bus0.busy), 32'd1);
    cmp("b2b d_held", 32'(bus0.d), 32'd14);
    drive(1'b0, 16'd200, 8'd9);
    drain();

    // Randomised operands
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: v = 8'd0;
        1: v = 8'd1;
        2: v = 8'd2;
        3: v = 8'd255;
        default: v = 8'($urandom_range(1, 255));
      endcase
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: c = 16'd0;
        1: c = 16'hFFFF;
        default: c = 16'($urandom);
      endcase
      issue(c, v);
      if (sel == 2) begin
        // occasionally poke calculate mid-operation
        @(negedge clk);
        drive(1'b1, 16'($urandom), 8'($urandom));
        @(posedge clk);
        #1;
        drive(1'b0, 16'd0, 8'd0);
      end
    end
    drain();
    repeat (25) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
